// File: rtl/rsfq_toggle_deser_pkg.sv
// rsfq_tb_pkg: shared types and helpers for the RSFQ toggle deserializer.
//   deser_state_t : SKIP (startup settling) / RUN (bit capture)
//   ptr_w()       : FIFO index width for a given depth
package rsfq_tb_pkg;

    typedef enum logic {
        SKIP = 1'b0,
        RUN  = 1'b1
    } deser_state_t;

    // Index width for a power-of-2 FIFO; never narrower than 1 bit.
    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/rsfq_toggle_deser_fifo.sv
// rsfq_sync_fifo: single-clock FIFO, registered write, head word shown
// combinationally from storage (no bypass: a word pushed into an empty FIFO
// appears the cycle after the push).
// Ports:
//   clk, rst_n       clock, synchronous active-low reset (pointers only)
//   i_push, i_data   write request / word
//   i_pop            read request; ignored while empty
//   o_data           head word, forced to 0 while empty
//   o_full, o_empty  occupancy flags
// A push while full is accepted only if a pop happens in the same cycle.
module rsfq_sync_fifo
    import rsfq_tb_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int PW = ptr_w(DEPTH);

    // Pointers carry one extra wrap bit to tell full from empty.
    logic [PW:0]      r_wr;
    logic [PW:0]      r_rd;
    logic [WIDTH-1:0] r_mem [DEPTH];

    logic w_do_push;
    logic w_do_pop;

    assign o_empty   = (r_wr == r_rd);
    assign o_full    = (r_wr[PW] != r_rd[PW]) && (r_wr[PW-1:0] == r_rd[PW-1:0]);
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);
    assign o_data    = o_empty ? '0 : r_mem[r_rd[PW-1:0]];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr <= '0;
            r_rd <= '0;
        end else begin
            if (w_do_push) r_wr <= r_wr + 1'b1;
            if (w_do_pop)  r_rd <= r_rd + 1'b1;
        end
    end

    // Storage needs no reset: reads are masked while empty.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr[PW-1:0]] <= i_data;
    end

endmodule

// File: rtl/rsfq_toggle_deser.sv
// rsfq_toggle_deser: capture stage for toggle-encoded RSFQ gate outputs.
// Every level change on pulse_in is one SFQ pulse = logical 1 for that clock
// period. Bits are packed LSB-first into WIDTH-bit words and queued in a FIFO
// read over a valid/ready handshake.
// Ports:
//   clk, rst_n       clock (one bit period per cycle), sync active-low reset
//   pulse_in         toggle-encoded line from the upstream gate
//   word_data        FIFO head word (bit 0 = first bit received)
//   word_valid       FIFO non-empty
//   word_ready       consumer accepts head word when word_valid is high
//   overflow         sticky: a completed word was dropped on a full FIFO
//   bit_count        bits gathered in the current partial frame
//   word_parity_err  (RSFQ_DESER_PARITY_EN only) even-parity mismatch of the
//                    head frame, valid with word_valid
// Build option: RSFQ_DESER_PARITY_EN adds a trailing even-parity bit to every
// frame (frame = WIDTH+1 bits); the parity bit is checked, not stored.
module rsfq_toggle_deser
    import rsfq_tb_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int DEPTH       = 4,
    parameter int SKIP_CYCLES = 0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       pulse_in,
    output logic [WIDTH-1:0]           word_data,
    output logic                       word_valid,
    input  logic                       word_ready,
    output logic                       overflow,
    output logic [$clog2(WIDTH+1)-1:0] bit_count
`ifdef RSFQ_DESER_PARITY_EN
    ,
    output logic                       word_parity_err
`endif
);

    localparam int CW = $clog2(WIDTH+1);
    localparam int SW = (SKIP_CYCLES > 0) ? $clog2(SKIP_CYCLES+1) : 1;
`ifdef RSFQ_DESER_PARITY_EN
    localparam int FRAME = WIDTH + 1;
    localparam int FW    = WIDTH + 1;
`else
    localparam int FRAME = WIDTH;
    localparam int FW    = WIDTH;
`endif
    localparam deser_state_t RST_STATE = (SKIP_CYCLES > 0) ? SKIP : RUN;

    deser_state_t     r_state;
    deser_state_t     w_state_nxt;
    logic [SW-1:0]    r_skip;
    logic             r_last;
    logic [WIDTH-1:0] r_shift;
    logic [CW-1:0]    r_cnt;
    logic             r_ovf;

    logic             w_bit;
    logic             w_run;
    logic             w_frame_end;
    logic [WIDTH-1:0] w_word;
    logic [FW-1:0]    w_push_data;
    logic [FW-1:0]    w_head;
    logic             w_full;
    logic             w_empty;
    logic             w_pop;

    assign w_bit       = pulse_in ^ r_last;
    assign w_run       = (r_state == RUN);
    assign w_frame_end = w_run && (r_cnt == CW'(FRAME-1));
    assign w_pop       = word_valid && word_ready;

    // Shift register with the current bit dropped in at index bit_count.
    // During a parity bit no data index matches, so the word is unchanged.
    always_comb begin
        w_word = r_shift;
        for (int i = 0; i < WIDTH; i++) begin
            if (r_cnt == CW'(i)) w_word[i] = w_bit;
        end
    end

`ifdef RSFQ_DESER_PARITY_EN
    // Even parity: data ones plus parity bit must be even.
    assign w_push_data = {(^r_shift) ^ w_bit, r_shift};
`else
    assign w_push_data = w_word;
`endif

    always_comb begin
        w_state_nxt = r_state;
        if (r_state == SKIP && r_skip == SW'(1)) w_state_nxt = RUN;
    end

    always_ff @(posedge clk) begin
        // Line level is always tracked, so reset and SKIP never leave a
        // stale level that would decode as a spurious 1.
        r_last <= pulse_in;
        if (!rst_n) begin
            r_state <= RST_STATE;
            r_skip  <= SW'(SKIP_CYCLES);
            r_shift <= '0;
            r_cnt   <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == SKIP) r_skip <= r_skip - 1'b1;
            if (w_run) begin
                r_shift <= w_word;
                r_cnt   <= w_frame_end ? '0 : r_cnt + 1'b1;
            end
            if (w_frame_end && w_full && !w_pop) r_ovf <= 1'b1;
        end
    end

    rsfq_sync_fifo #(
        .WIDTH (FW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_frame_end),
        .i_data  (w_push_data),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign word_valid = !w_empty;
    assign word_data  = w_head[WIDTH-1:0];
    assign overflow   = r_ovf;
    assign bit_count  = r_cnt;
`ifdef RSFQ_DESER_PARITY_EN
    assign word_parity_err = w_head[WIDTH];
`endif

endmodule
